// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines plus a registered falling-edge detector.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic fall,
    output logic dat_s
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_dat_meta;
    logic r_dat_sync;
    logic r_fall;
    logic r_dat_s;

    // Data is registered alongside the edge strobe so both reach the FSM together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_meta <= 1'b0;
            r_clk_sync <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
            r_fall     <= 1'b0;
            r_dat_s    <= 1'b0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
            r_fall     <= r_clk_prev & ~r_clk_sync;
            r_dat_s    <= r_dat_sync;
        end
    end

    assign fall  = r_fall;
    assign dat_s = r_dat_s;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver with timeout recovery and E0/F0 prefix folding into key events.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic            w_fall;
    logic            w_dat_s;
    logic            w_timeout;
    logic            w_good;
    logic            w_err;
    ps2_state_e      w_state_next;

    ps2_state_e      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [CntW-1:0] r_to_cnt;
    logic            r_byte_valid;
    logic [7:0]      r_byte_data;
    logic            r_frame_err;
    logic            r_ext_pend;
    logic            r_rel_pend;
    logic            r_key_valid;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_rel;

    ps2_sync_edge u_sync_edge (
        .i_clk     (CLOCK_50),
        .i_reset   (reset),
        .i_ps2_clk (ps2_clk),
        .i_ps2_dat (ps2_dat),
        .fall      (w_fall),
        .dat_s     (w_dat_s)
    );

    // A falling edge in the same cycle suppresses the timeout.
    assign w_timeout = (r_state != StIdle) && !w_fall &&
                       (r_to_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        w_good       = 1'b0;
        w_err        = 1'b0;
        if (w_timeout) begin
            w_state_next = StIdle;
            w_err        = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!w_dat_s) begin
                        w_state_next = StData;
                    end
                end
                StData: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = StParity;
                    end
                end
                StParity: begin
                    w_state_next = StStop;
                end
                StStop: begin
                    w_state_next = StIdle;
                    if (w_dat_s && ps2_parity_ok(r_shift, r_parity)) begin
                        w_good = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= StIdle;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_byte_valid <= w_good;
            r_frame_err  <= w_err;
            if (w_good) begin
                r_byte_data <= r_shift;
            end

            if (r_state == StIdle || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CntW'(1);
            end

            if (w_timeout) begin
                r_shift   <= 8'd0;
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                unique case (r_state)
                    StIdle:   r_bit_cnt <= 3'd0;
                    StData: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    StParity: r_parity <= w_dat_s;
                    StStop:   r_bit_cnt <= 3'd0;
                    default:  r_bit_cnt <= 3'd0;
                endcase
            end
        end
    end

    // Key decoder runs one cycle behind the frame FSM on its registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ext_pend  <= 1'b0;
            r_rel_pend  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'd0;
            r_key_ext   <= 1'b0;
            r_key_rel   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_frame_err) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end else if (r_byte_valid) begin
                if (r_byte_data == PS2_EXT_PREFIX) begin
                    r_ext_pend <= 1'b1;
                end else if (r_byte_data == PS2_BRK_PREFIX) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    r_key_code  <= r_byte_data;
                    r_key_ext   <= r_ext_pend;
                    r_key_rel   <= r_rel_pend;
                    r_key_valid <= 1'b1;
                    r_ext_pend  <= 1'b0;
                    r_rel_pend  <= 1'b0;
                end
            end
        end
    end

    assign byte_valid   = r_byte_valid;
    assign byte_data    = r_byte_data;
    assign frame_err    = r_frame_err;
    assign key_valid    = r_key_valid;
    assign key_code     = r_key_code;
    assign key_extended = r_key_ext;
    assign key_released = r_key_rel;

endmodule
